// File: rtl/si7021_i2c_responder.sv
// si7021_i2c_responder
//   I2C target emulating a Si7021 temperature sensor. It answers address
//   I2C_ADDR and accepts two commands: 0xF3 (measure, no-hold) and 0xFE
//   (soft reset). While a simulated conversion is pending, or when no result
//   exists yet, a read address is NAKed. When a result is ready, a read
//   returns MSB, LSB and a check byte, followed by 0xFF for as long as the
//   master keeps ACKing.
//
//   Optional feature macro: SI7021_RESP_CRC_EN
//     defined   : the check byte is CRC-8 (poly 0x31, init 0x00) over MSB
//                 then LSB, computed when temp_code is latched.
//     undefined : the check byte is the constant 0x00 and no CRC logic exists.
//
// Parameters
//   I2C_ADDR     7-bit target address
//   CONV_CYCLES  clk cycles of simulated conversion time after 0xF3
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   scl        in   I2C clock from master (asynchronous)
//   sda_i      in   SDA as seen on the pad (asynchronous)
//   sda_oe     out  1 = pull SDA low, 0 = release
//   temp_code  in   raw temperature code, latched when 0xF3 is ACKed
//   soft_rst   out  1-cycle pulse when 0xFE is ACKed
//   conv_busy  out  high while the simulated conversion runs
//   read_done  out  1-cycle pulse at the ACK/NAK clock of the check byte

module si7021_i2c_responder #(
  parameter logic [6:0] I2C_ADDR    = 7'h40,
  parameter int         CONV_CYCLES = 700_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic [15:0] temp_code,
  output logic        soft_rst,
  output logic        conv_busy,
  output logic        read_done
);

  localparam int CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CONV_CYCLES - 1);

  localparam logic [7:0] CMD_MEASURE = 8'hF3;
  localparam logic [7:0] CMD_SOFTRST = 8'hFE;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, TX_BYTE, TX_ACK, IGNORE
  } state_t;

  state_t           state;
  logic [2:0]       bit_cnt;
  logic [1:0]       byte_idx;     // 0: MSB on wire, 1: LSB, 2: CHK, 3: 0xFF fill
  logic             rd_xfer;
  logic             cmd_acked;
  logic             result_valid;
  logic [CNT_W-1:0] conv_cnt;

  logic scl_p0, scl_p1, scl_p2;
  logic sda_p0, sda_p1, sda_p2;

  logic [7:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] msb_r;
  logic [7:0] lsb_r;
  logic [7:0] chk_byte;

`ifdef SI7021_RESP_CRC_EN
  logic [7:0] chk_r;

  // Bitwise CRC-8, poly x^8+x^5+x^4+1, init 0x00, MSB first, no final XOR.
  function automatic logic [7:0] crc8(input logic [15:0] data);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 15; i >= 0; i--) begin
      fb = c[7] ^ data[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h31 : 8'h00);
    end
    return c;
  endfunction

  assign chk_byte = chk_r;
`else
  assign chk_byte = 8'h00;
`endif

  // Edge and bus-condition decode on the synchronised (p1) and delayed (p2) copies.
  logic scl_rise, scl_fall, bus_start, bus_stop;
  logic [7:0] rx_byte;
  logic addr_match, rd_ok;

  assign scl_rise   = scl_p1 & ~scl_p2;
  assign scl_fall   = ~scl_p1 & scl_p2;
  assign bus_start  = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign bus_stop   = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;
  assign rx_byte    = {rx_shift[6:0], sda_p1};
  assign addr_match = (rx_byte[7:1] == I2C_ADDR);
  assign rd_ok      = result_valid & ~conv_busy;

  // Control: synchronisers, FSM, conversion timer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_p0       <= 1'b1;
      scl_p1       <= 1'b1;
      scl_p2       <= 1'b1;
      sda_p0       <= 1'b1;
      sda_p1       <= 1'b1;
      sda_p2       <= 1'b1;
      state        <= IDLE;
      bit_cnt      <= '0;
      byte_idx     <= '0;
      rd_xfer      <= 1'b0;
      cmd_acked    <= 1'b0;
      result_valid <= 1'b0;
      conv_cnt     <= '0;
      conv_busy    <= 1'b0;
      sda_oe       <= 1'b0;
      soft_rst     <= 1'b0;
      read_done    <= 1'b0;
    end else begin
      // Stage p0 -> p1: two-flop synchronisers; p1 -> p2: edge-detect delay.
      scl_p0 <= scl;
      scl_p1 <= scl_p0;
      scl_p2 <= scl_p1;
      sda_p0 <= sda_i;
      sda_p1 <= sda_p0;
      sda_p2 <= sda_p1;

      soft_rst  <= 1'b0;
      read_done <= 1'b0;

      // Conversion timer; command handling below may override it.
      if (conv_busy) begin
        if (conv_cnt == '0) begin
          conv_busy    <= 1'b0;
          result_valid <= 1'b1;
        end else begin
          conv_cnt <= conv_cnt - 1'b1;
        end
      end

      if (bus_start) begin
        state   <= ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else if (bus_stop) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
      end else if (scl_rise) begin
        case (state)
          ADDR: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              if (addr_match && !rx_byte[0]) begin
                state   <= ADDR_ACK;
                rd_xfer <= 1'b0;
              end else if (addr_match && rd_ok) begin
                state    <= ADDR_ACK;
                rd_xfer  <= 1'b1;
                byte_idx <= '0;
              end else begin
                state <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            state     <= rd_xfer ? TX_BYTE : CMD;
            bit_cnt   <= '0;
            cmd_acked <= 1'b0;
          end
          CMD: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              if (!cmd_acked && (rx_byte == CMD_MEASURE || rx_byte == CMD_SOFTRST))
                state <= CMD_ACK;
              else
                state <= IGNORE;
            end
          end
          CMD_ACK: begin
            // The ACK clock: the command is now accepted.
            state     <= CMD;
            cmd_acked <= 1'b1;
            if (rx_shift == CMD_MEASURE) begin
              conv_busy    <= 1'b1;
              conv_cnt     <= CNT_LOAD;
              result_valid <= 1'b0;
            end else begin
              soft_rst     <= 1'b1;
              conv_busy    <= 1'b0;
              result_valid <= 1'b0;
            end
          end
          TX_BYTE: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              state   <= TX_ACK;
            end
          end
          TX_ACK: begin
            if (byte_idx == 2'd2)
              read_done <= 1'b1;
            if (!sda_p1) begin
              state <= TX_BYTE;
              if (byte_idx != 2'd3)
                byte_idx <= byte_idx + 2'd1;
            end else begin
              state <= IGNORE;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        // SDA only ever changes while SCL is low.
        case (state)
          ADDR_ACK, CMD_ACK: sda_oe <= 1'b1;
          TX_BYTE:           sda_oe <= ~tx_shift[7];
          default:           sda_oe <= 1'b0;
        endcase
      end
    end
  end

  // Data path: shift registers and latched result, no reset needed.
  always_ff @(posedge clk) begin
    if (scl_rise) begin
      case (state)
        ADDR: begin
          rx_shift <= rx_byte;
          if (bit_cnt == 3'd7)
            tx_shift <= msb_r;
        end
        CMD:     rx_shift <= rx_byte;
        CMD_ACK: begin
          if (rx_shift == CMD_MEASURE) begin
            msb_r <= temp_code[15:8];
            lsb_r <= temp_code[7:0] & 8'hFC;
`ifdef SI7021_RESP_CRC_EN
            chk_r <= crc8({temp_code[15:8], temp_code[7:0] & 8'hFC});
`endif
          end
        end
        TX_BYTE: tx_shift <= {tx_shift[6:0], 1'b1};
        TX_ACK: begin
          case (byte_idx)
            2'd0:    tx_shift <= lsb_r;
            2'd1:    tx_shift <= chk_byte;
            default: tx_shift <= 8'hFF;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
